snoop_bus_ctrl: RTL

SNOOP_BUS_CTRL -- requirements
Module: snoop_bus_ctrl

---
 rtl/snoop_bus_ctrl.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: arbitrates icache/dcache traffic from CPUS cores onto a
// single RAM port and broadcasts snoops for coherence transitions.
// Build option: define SNOOP_FWD_EN to hand supplier write-back data straight
// to the requester in FWD instead of re-reading it from RAM afterwards.

// Per-core snoop outputs: the granted core never sees its own snoop.
module snoop_lane #(
  parameter int WORD_W = 32
) (
  input  logic              snp,
  input  logic              hold,
  input  logic              inv,
  input  logic              is_g,
  input  logic [WORD_W-1:0] addr,
  output logic              ccwait,
  output logic              ccinv,
  output logic [WORD_W-1:0] ccsnoopaddr
);
  assign ccwait      = (snp | hold) & ~is_g;
  assign ccinv       = snp & inv & ~is_g;
  assign ccsnoopaddr = (snp & ~is_g) ? addr : '0;
endmodule

module snoop_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  input  logic [CPUS-1:0]        ccwrite,
  input  logic [CPUS-1:0]        cctrans,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, WB, SNOOP, SNRESP, FWD, RAMRD, IFETCH} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   g, g_n;     // granted core
  logic [IW-1:0]   s, s_n;     // supplier core during FWD
  logic [IW-1:0]   rr, rr_n;   // round-robin start pointer

  // per-core views of the flat buses
  logic [CPUS-1:0][WORD_W-1:0] iaddr_v, daddr_v, dstore_v;
  logic [CPUS-1:0][WORD_W-1:0] iload_v, dload_v, snoop_v;

  assign iaddr_v     = iaddr;
  assign daddr_v     = daddr;
  assign dstore_v    = dstore;
  assign iload       = iload_v;
  assign dload       = dload_v;
  assign ccsnoopaddr = snoop_v;

  // First set bit of req at or after ptr, wrapping; MSB of result = found.
  function automatic logic [IW:0] rr_pick(input logic [CPUS-1:0] req,
                                          input logic [IW-1:0]   ptr);
    logic [IW:0]   r;
    logic [IW-1:0] ix;
    int            idx;
    r = '0;
    for (int k = CPUS-1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= CPUS) idx = idx - CPUS;
      ix = IW'(idx);
      if (req[ix]) r = {1'b1, ix};
    end
    return r;
  endfunction

  // Pointer value after a completed transaction by core x.
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (int'(x) == CPUS-1) ? '0 : x + 1'b1;
  endfunction

  logic [IW:0]   wb_pick, tr_pick, if_pick;
  logic          sup_found;
  logic [IW-1:0] sup;
  logic          access;
  logic          snp, hold;

  // Request classes: plain write-backs outrank coherence, which outranks fetch.
  assign wb_pick = rr_pick(dWEN & ~cctrans, rr);
  assign tr_pick = rr_pick(cctrans, rr);
  assign if_pick = rr_pick(iREN, rr);
  assign access  = (ramstate == RS_ACCESS);

  // Supplier search: lowest-index other core currently writing back.
  always_comb begin
    sup_found = 1'b0;
    sup       = '0;
    for (int c = CPUS-1; c >= 0; c--) begin
      if (dWEN[c] && (IW'(c) != g)) begin
        sup_found = 1'b1;
        sup       = IW'(c);
      end
    end
  end

  // State, grant and pointer registers; reset lands in IDLE with rr at core 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      g     <= '0;
      s     <= '0;
      rr    <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
      s     <= s_n;
      rr    <= rr_n;
    end
  end

  // Next state and all bus outputs; a dropped granted request aborts to IDLE
  // without moving rr, while the strobes of the current cycle stay up.
  always_comb begin
    state_n  = state;
    g_n      = g;
    s_n      = s;
    rr_n     = rr;
    iwait    = '1;
    dwait    = '1;
    iload_v  = '0;
    dload_v  = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    snp      = 1'b0;
    hold     = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (wb_pick[IW]) begin
            g_n     = wb_pick[IW-1:0];
            state_n = WB;
          end else if (tr_pick[IW]) begin
            g_n = tr_pick[IW-1:0];
            if (CPUS > 1) begin
              state_n = SNOOP;
            end else if (dREN[tr_pick[IW-1:0]]) begin
              state_n = RAMRD;
            end else begin
              // lone core upgrading: nobody to snoop, done on the spot
              dwait[tr_pick[IW-1:0]] = 1'b0;
              rr_n = inc(tr_pick[IW-1:0]);
            end
          end else if (if_pick[IW]) begin
            g_n     = if_pick[IW-1:0];
            state_n = IFETCH;
          end
        end
        WB: begin
          ramWEN   = 1'b1;
          ramaddr  = daddr_v[g];
          ramstore = dstore_v[g];
          if (!dWEN[g]) begin
            state_n = IDLE;
          end else if (access) begin
            dwait[g] = 1'b0;
            state_n  = IDLE;
            rr_n     = inc(g);
          end
        end
        SNOOP: begin
          snp     = 1'b1;
          state_n = cctrans[g] ? SNRESP : IDLE;
        end
        SNRESP: begin
          snp = 1'b1;
          if (!cctrans[g]) begin
            state_n = IDLE;
          end else if (sup_found) begin
            s_n     = sup;
            state_n = FWD;
          end else if (dREN[g]) begin
            state_n = RAMRD;
          end else begin
            dwait[g] = 1'b0;
            state_n  = IDLE;
            rr_n     = inc(g);
          end
        end
        FWD: begin
          hold     = 1'b1;
          ramWEN   = 1'b1;
          ramaddr  = daddr_v[s];
          ramstore = dstore_v[s];
          if (!cctrans[g]) begin
            state_n = IDLE;
          end else if (access) begin
            dwait[s] = 1'b0;
`ifdef SNOOP_FWD_EN
            dload_v[g] = dstore_v[s];
            dwait[g]   = 1'b0;
            state_n    = IDLE;
            rr_n       = inc(g);
`else
            state_n = RAMRD;
`endif
          end
        end
        RAMRD: begin
          ramREN  = 1'b1;
          ramaddr = daddr_v[g];
          if (!cctrans[g]) begin
            state_n = IDLE;
          end else if (access) begin
            dload_v[g] = ramload;
            dwait[g]   = 1'b0;
            state_n    = IDLE;
            rr_n       = inc(g);
          end
        end
        IFETCH: begin
          ramREN  = 1'b1;
          ramaddr = iaddr_v[g];
          if (!iREN[g]) begin
            state_n = IDLE;
          end else if (access) begin
            iload_v[g] = ramload;
            iwait[g]   = 1'b0;
            state_n    = IDLE;
            rr_n       = inc(g);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  genvar c;
  generate
    for (c = 0; c < CPUS; c++) begin : g_lane
      snoop_lane #(.WORD_W(WORD_W)) u_lane (
        .snp         (snp),
        .hold        (hold),
        .inv         (ccwrite[g]),
        .is_g        (g == IW'(c)),
        .addr        (daddr_v[g]),
        .ccwait      (ccwait[c]),
        .ccinv       (ccinv[c]),
        .ccsnoopaddr (snoop_v[c])
      );
    end
  endgenerate

endmodule
